// File: rtl/corelet_ctrl_if.sv
// Control bus between the core and the corelet tile sequencer.
// master: core side (start/tile setup, corelet status); slave: the sequencer.
interface corelet_ctrl_if #(
  parameter int len_bw  = 11,
  parameter int addr_bw = 11
);
  logic               start;
  logic [len_bw-1:0]  n_act;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] x_base;
  logic               L0_full;
  logic               ofifo_valid;
  logic [33:0]        inst;
  logic               mem_cen;
  logic [addr_bw-1:0] mem_addr;
  logic               busy;
  logic               done;

  modport master (
    output start, n_act, w_base, x_base, L0_full, ofifo_valid,
    input  inst, mem_cen, mem_addr, busy, done
  );

  modport slave (
    input  start, n_act, w_base, x_base, L0_full, ofifo_valid,
    output inst, mem_cen, mem_addr, busy, done
  );
endinterface

// File: rtl/corelet_ctrl.sv
// Tile sequencer: weight load, kernel push, settle, activation stream, psum drain.
// All outputs registered; CORELET_CTRL_ACC_EN enables SFP accumulate (inst[33]) and delays done by one cycle.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 11,
  parameter int addr_bw = 11
) (
  input  logic         clk,
  input  logic         reset,
  corelet_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WLOAD, WPUSH, SETTLE, EXEC, DRAIN} state_t;

  localparam logic [len_bw-1:0] ROW_N    = len_bw'(row);
  localparam logic [len_bw-1:0] SETTLE_N = len_bw'(row + col);

  state_t             state;
  logic [len_bw-1:0]  n_act_q;
  logic [addr_bw-1:0] w_base_q;
  logic [addr_bw-1:0] x_base_q;
  logic [len_bw-1:0]  rd_cnt;
  logic [len_bw-1:0]  ph_cnt;
  logic [len_bw-1:0]  occ;
  logic [len_bw-1:0]  psum_cnt;
  logic [len_bw-1:0]  occ_nx;
  logic [len_bw:0]    psum_nx;
`ifdef CORELET_CTRL_ACC_EN
  logic               fin;
`endif

  // L0 occupancy as it will stand in the next cycle, given this cycle's write/read
  assign occ_nx  = occ + len_bw'(bus.inst[2]) - len_bw'(bus.inst[3]);
  assign psum_nx = {1'b0, psum_cnt} + {{len_bw{1'b0}}, bus.ofifo_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      n_act_q      <= '0;
      w_base_q     <= '0;
      x_base_q     <= '0;
      rd_cnt       <= '0;
      ph_cnt       <= '0;
      occ          <= '0;
      psum_cnt     <= '0;
      bus.inst     <= '0;
      bus.mem_cen  <= 1'b1;
      bus.mem_addr <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
`ifdef CORELET_CTRL_ACC_EN
      fin          <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_act_q  <= bus.n_act;
            w_base_q <= bus.w_base;
            x_base_q <= bus.x_base;
            occ      <= '0;
            psum_cnt <= '0;
            rd_cnt   <= '0;
            bus.busy <= 1'b1;
            state    <= WLOAD;
            // First weight read goes out with the accept so its address shows in cycle 1
            if (!bus.L0_full) begin
              bus.mem_cen  <= 1'b0;
              bus.mem_addr <= bus.w_base;
              rd_cnt       <= len_bw'(1);
            end
          end
        end
        WLOAD: begin
          bus.inst[2] <= !bus.mem_cen;
          if (rd_cnt == ROW_N && bus.mem_cen) begin
            bus.inst[3:0] <= 4'b1001;
            ph_cnt        <= len_bw'(1);
            state         <= WPUSH;
          end else if (rd_cnt != ROW_N && !bus.L0_full) begin
            bus.mem_cen  <= 1'b0;
            bus.mem_addr <= w_base_q + addr_bw'(rd_cnt);
            rd_cnt       <= rd_cnt + len_bw'(1);
          end else begin
            bus.mem_cen <= 1'b1;
          end
        end
        WPUSH: begin
          if (ph_cnt == ROW_N) begin
            bus.inst[3:0] <= 4'b0000;
            ph_cnt        <= len_bw'(1);
            state         <= SETTLE;
          end else begin
            ph_cnt <= ph_cnt + len_bw'(1);
          end
        end
        SETTLE: begin
          if (ph_cnt == SETTLE_N) begin
            rd_cnt <= '0;
            if (n_act_q == '0) begin
              state <= DRAIN;
            end else begin
              state <= EXEC;
              if (!bus.L0_full) begin
                bus.mem_cen  <= 1'b0;
                bus.mem_addr <= x_base_q;
                rd_cnt       <= len_bw'(1);
              end
            end
          end else begin
            ph_cnt <= ph_cnt + len_bw'(1);
          end
        end
        EXEC: begin
          psum_cnt <= psum_nx[len_bw-1:0];
          occ      <= occ_nx;
          if (rd_cnt == n_act_q && bus.mem_cen && !bus.inst[2] && occ_nx == '0) begin
            bus.inst[3:0] <= 4'b0000;
            state         <= DRAIN;
          end else begin
            bus.inst[2] <= !bus.mem_cen;
            bus.inst[3] <= (occ_nx != '0);
            bus.inst[1] <= (occ_nx != '0);
            if (rd_cnt != n_act_q && !bus.L0_full) begin
              bus.mem_cen  <= 1'b0;
              bus.mem_addr <= x_base_q + addr_bw'(rd_cnt);
              rd_cnt       <= rd_cnt + len_bw'(1);
            end else begin
              bus.mem_cen <= 1'b1;
            end
          end
        end
        DRAIN: begin
`ifdef CORELET_CTRL_ACC_EN
          // Hold one extra cycle so the accumulate of the last psum lands before done
          if (fin) begin
            fin      <= 1'b0;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            psum_cnt <= psum_nx[len_bw-1:0];
            if (psum_nx >= {1'b0, n_act_q}) fin <= 1'b1;
          end
`else
          psum_cnt <= psum_nx[len_bw-1:0];
          if (psum_nx >= {1'b0, n_act_q}) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
`ifdef CORELET_CTRL_ACC_EN
      bus.inst[33] <= (state == EXEC || state == DRAIN) && bus.ofifo_valid;
`endif
    end
  end
endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl with an event-schedule reference model.
module tb_corelet_ctrl;
  localparam int MAXC = 128;
`ifdef CORELET_CTRL_ACC_EN
  localparam int ACC_X = 1;
`else
  localparam int ACC_X = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  corelet_ctrl_if bus ();
  corelet_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic        st_v [MAXC];
  logic        l0f_v[MAXC];
  logic        ofv_v[MAXC];
  logic [33:0] e_inst[MAXC];
  logic        e_cen [MAXC];
  logic [10:0] e_addr[MAXC];
  logic        e_busy[MAXC];
  logic        e_done[MAXC];
  int m_done, m_s;
  int obs_done, obs_inst1;

  task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_v[i] = 1'b0; l0f_v[i] = 1'b0; ofv_v[i] = 1'b0;
    end
  endtask

  // Reference: schedule reads, writes, pushes and L0 reads as events on a cycle timeline
  task automatic build_model(input int n, input logic [10:0] wb, input logic [10:0] xb);
    int t0, cnt, c, lw, s, d, last, occ, nv, vn, dn;
    logic [10:0] held;
    t0 = -1;
    for (int i = 0; i < MAXC; i++) begin
      e_inst[i] = '0; e_cen[i] = 1'b1; e_addr[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
      if (st_v[i] && t0 < 0) t0 = i;
    end
    m_done = -1; m_s = -1;
    if (t0 < 0) return;
    cnt = 0; c = t0 + 1; lw = c;
    while (cnt < 8 && c < MAXC - 1) begin
      if (!l0f_v[c-1]) begin
        e_cen[c] = 1'b0; e_addr[c] = wb + 11'(cnt); e_inst[c+1][2] = 1'b1; lw = c + 1; cnt++;
      end
      c++;
    end
    for (int k = 1; k <= 8; k++) begin e_inst[lw+k][0] = 1'b1; e_inst[lw+k][3] = 1'b1; end
    s = lw + 8 + 16 + 1;
    cnt = 0; c = s;
    while (cnt < n && c < MAXC - 1) begin
      if (!l0f_v[c-1]) begin
        e_cen[c] = 1'b0; e_addr[c] = xb + 11'(cnt); e_inst[c+1][2] = 1'b1; cnt++;
      end
      c++;
    end
    occ = 0; last = s - 1;
    for (c = s; c < MAXC; c++) begin
      if (occ > 0) begin e_inst[c][3] = 1'b1; e_inst[c][1] = 1'b1; last = c; end
      occ = occ + int'(e_inst[c][2]) - int'(e_inst[c][3]);
    end
    d = last + 1; vn = -1; nv = 0;
    for (c = s; c < MAXC && nv < n; c++)
      if (ofv_v[c]) begin nv++; if (nv == n) vn = c; end
    dn = ((d + 1) > (vn + 1)) ? d + 1 : vn + 1;
    dn = dn + ACC_X;
    if (ACC_X == 1)
      for (c = s; c < dn && c + 1 < MAXC; c++) e_inst[c+1][33] = ofv_v[c];
    for (c = t0 + 1; c < dn && c < MAXC; c++) e_busy[c] = 1'b1;
    if (dn < MAXC) e_done[dn] = 1'b1;
    held = '0;
    for (c = 0; c < MAXC; c++) begin
      if (!e_cen[c]) held = e_addr[c];
      e_addr[c] = held;
    end
    m_done = dn; m_s = s;
  endtask

  task automatic do_reset(input bit check_state);
    reset = 1'b1;
    bus.start = 1'b0; bus.L0_full = 1'b0; bus.ofifo_valid = 1'b0;
    bus.n_act = '0; bus.w_base = '0; bus.x_base = '0;
    repeat (2) @(posedge clk);
    #1;
    if (check_state) begin
      chk("rst_inst", 0, bus.inst, 0);
      chk("rst_cen", 0, bus.mem_cen, 1);
      chk("rst_addr", 0, bus.mem_addr, 0);
      chk("rst_busy", 0, bus.busy, 0);
      chk("rst_done", 0, bus.done, 0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_tile(input int ncyc, input int n, input logic [10:0] wb, input logic [10:0] xb);
    bus.n_act = 11'(n); bus.w_base = wb; bus.x_base = xb;
    build_model(n, wb, xb);
    obs_done = -1; obs_inst1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      bus.start = st_v[c]; bus.L0_full = l0f_v[c]; bus.ofifo_valid = ofv_v[c];
      @(negedge clk);
      chk("inst", c, bus.inst, e_inst[c]);
      chk("mem_cen", c, bus.mem_cen, e_cen[c]);
      chk("mem_addr", c, bus.mem_addr, e_addr[c]);
      chk("busy", c, bus.busy, e_busy[c]);
      chk("done", c, bus.done, e_done[c]);
      if (bus.done && obs_done < 0) obs_done = c;
      if (bus.inst[1]) obs_inst1++;
    end
  endtask

  initial begin
    // Basic tile: 4 activations, psums arrive after EXEC
    do_reset(1'b1);
    clear_stim();
    st_v[0] = 1'b1;
    ofv_v[42] = 1'b1; ofv_v[43] = 1'b1; ofv_v[45] = 1'b1; ofv_v[46] = 1'b1;
    run_tile(52, 4, 11'h010, 11'h040);
    chk("t1_model_exec", 0, m_s, 34);
    chk("t1_model_done", 0, m_done, 47 + ACC_X);
    chk("t1_done_cycle", 0, obs_done, 47 + ACC_X);
    chk("t1_exec_cycles", 0, obs_inst1, 4);

    // L0_full stall mid-WLOAD
    do_reset(1'b0);
    clear_stim();
    st_v[0] = 1'b1;
    l0f_v[3] = 1'b1; l0f_v[4] = 1'b1; l0f_v[5] = 1'b1;
    ofv_v[44] = 1'b1; ofv_v[45] = 1'b1;
    run_tile(52, 2, 11'h010, 11'h020);
    chk("t2_model_exec", 0, m_s, 37);
    chk("t2_done_cycle", 0, obs_done, 46 + ACC_X);

    // Empty tile with wrapping weight addresses; early valid ignored
    do_reset(1'b0);
    clear_stim();
    st_v[0] = 1'b1;
    ofv_v[20] = 1'b1;
    run_tile(40, 0, 11'h7FC, 11'h100);
    chk("t3_done_cycle", 0, obs_done, 35 + ACC_X);
    chk("t3_exec_cycles", 0, obs_inst1, 0);

    // EXEC stall, wrapping activation addresses, psums counted during EXEC
    do_reset(1'b0);
    clear_stim();
    st_v[0] = 1'b1;
    l0f_v[34] = 1'b1;
    ofv_v[36] = 1'b1; ofv_v[37] = 1'b1; ofv_v[38] = 1'b1;
    run_tile(46, 3, 11'h000, 11'h7FF);
    chk("t4_done_cycle", 0, obs_done, 41 + ACC_X);
    chk("t4_exec_cycles", 0, obs_inst1, 3);

    // Start while busy is ignored; async reset during EXEC aborts the tile
    do_reset(1'b0);
    clear_stim();
    st_v[0] = 1'b1; st_v[5] = 1'b1;
    run_tile(36, 4, 11'h010, 11'h040);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_inst", 36, bus.inst, 0);
    chk("ar_cen", 36, bus.mem_cen, 1);
    chk("ar_addr", 36, bus.mem_addr, 0);
    chk("ar_busy", 36, bus.busy, 0);
    chk("ar_done", 36, bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_busy", c, bus.busy, 0);
      chk("post_done", c, bus.done, 0);
      chk("post_cen", c, bus.mem_cen, 1);
      chk("post_inst", c, bus.inst, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
